// File: rtl/fb_scan_reader.sv
// fb_scan_reader: row-major read scanner for the 96x64 RGB565 frame buffer.
// Ports: clk/rst_n; start/abort/busy/done control; rd_addr/rd_data BRAM
// read port (1-clk latency); pix_* valid/ready pixel stream with x/y and
// sof/eol/eof markers, fed from a 2-entry output skid FIFO.
module fb_scan_reader #(
    parameter int WIDTH  = 96,
    parameter int HEIGHT = 64,
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [6:0]        pix_x,
    output logic [5:0]        pix_y,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof
);

    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [6:0]        X_LAST = 7'(WIDTH - 1);
    localparam logic [5:0]        Y_LAST = 6'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN
    } state_t;

    state_t            state;
    logic              inflight;
    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [DATA_W-1:0] mem [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] occ;

    assign pop   = pix_valid & pix_ready;
    assign push  = inflight;
    // Occupancy after this cycle's pop, counting the read still in flight;
    // issuing only below 2 is what keeps the FIFO from overflowing.
    assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue = (state == S_READ) && (occ < 3'd2);

    assign busy      = (state != S_IDLE);
    assign pix_valid = (count != 2'd0);
    assign pix_data  = mem[rd_ptr];
    assign pix_sof   = (pix_x == 7'd0) && (pix_y == 6'd0);
    assign pix_eol   = (pix_x == X_LAST);
    assign pix_eof   = pix_eol && (pix_y == Y_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            rd_addr  <= '0;
            inflight <= 1'b0;
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
            pix_x    <= 7'd0;
            pix_y    <= 6'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Abort also wins over start while idle; the clears are
                // no-ops there since the datapath is already empty.
                state    <= S_IDLE;
                rd_addr  <= '0;
                inflight <= 1'b0;
                count    <= 2'd0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                pix_x    <= 7'd0;
                pix_y    <= 6'd0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    rd_addr <= (rd_addr == A_LAST) ? '0
                                                   : rd_addr + ADDR_W'(1);
                end
                if (push) begin
                    mem[wr_ptr] <= rd_data;
                    wr_ptr      <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                    if (pix_eol) begin
                        pix_x <= 7'd0;
                        pix_y <= (pix_y == Y_LAST) ? 6'd0 : pix_y + 6'd1;
                    end else begin
                        pix_x <= pix_x + 7'd1;
                    end
                end
                count <= count + {1'b0, push} - {1'b0, pop};

                unique case (state)
                    S_IDLE: begin
                        if (start) begin
                            state <= S_READ;
                        end
                    end
                    S_READ: begin
                        if (issue && (rd_addr == A_LAST)) begin
                            state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (pop && pix_eof) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fb_scan_reader.sv
// tb_fb_scan_reader: randomized-ready bench for fb_scan_reader with a
// BRAM model (mem[i]=i) and an index-based reference of the pixel stream.
module tb_fb_scan_reader;

    localparam int NPIX = 96 * 64;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [12:0] rd_addr;
    logic [15:0] rd_data;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [6:0]  pix_x;
    logic [5:0]  pix_y;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;

    logic [15:0] mem [8192];

    int n_chk;
    int n_pass;

    fb_scan_reader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .pix_data (pix_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .pix_sof  (pix_sof),
        .pix_eol  (pix_eol),
        .pix_eof  (pix_eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] exp_pix(input int k);
        int x;
        int y;
        x = k % 96;
        y = k / 96;
        return {16'(k), 7'(x), 6'(y), 1'(k == 0), 1'(x == 95),
                1'(k == NPIX - 1)};
    endfunction

    function automatic logic [31:0] got_pix();
        return {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
    endfunction

    function automatic logic [63:0] ctl_zero();
        return 64'({pix_valid, busy, done, rd_addr, pix_x, pix_y, pix_data});
    endfunction

    // mode: 0 ready high, 1 ready low 10 clks then high, 2 random ready.
    // ev_kind: 0 none, 1 start again, 2 abort, 3 reset, at beat ev_beat.
    task automatic scan(input int mode, input int ev_beat, input int ev_kind);
        int k;
        int cyc;
        int ndone;
        bit exp_done;
        bit active;
        bit fin;
        bit ev_done;
        k        = 0;
        ndone    = 0;
        exp_done = 0;
        active   = 1;
        fin      = 0;
        ev_done  = 0;
        cyc      = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_up", 64'(busy), 64'(1));
        while (!fin) begin
            start = 1'b0;
            chk("done", 64'(done), 64'(exp_done));
            if (done) ndone++;
            chk("busy", 64'(busy), 64'(active));
            if (exp_done) begin
                fin = 1;
            end else begin
                if (cyc == 1) chk("lat1", 64'(pix_valid), 64'(0));
                if (cyc == 2) chk("lat2", 64'(pix_valid), 64'(1));
                if (mode == 1 && cyc == 10)
                    chk("stall_addr", 64'(rd_addr), 64'(2));
                if (pix_valid) chk("beat", 64'(got_pix()), 64'(exp_pix(k)));
                case (mode)
                    0:       pix_ready = 1'b1;
                    1:       pix_ready = (cyc >= 10);
                    default: pix_ready = 1'($urandom_range(0, 1));
                endcase
                if (ev_kind != 0 && !ev_done && pix_valid && k == ev_beat) begin
                    ev_done = 1;
                    if (ev_kind == 1) begin
                        start = 1'b1;
                    end else if (ev_kind == 2) begin
                        abort = 1'b1;
                        @(posedge clk);
                        #1;
                        abort = 1'b0;
                        chk("abort", 64'({pix_valid, busy, done, rd_addr,
                                          pix_x, pix_y}), 64'(0));
                        @(posedge clk);
                        #1;
                        chk("abort_nodone", 64'({done, busy, pix_valid}),
                            64'(0));
                        return;
                    end else begin
                        rst_n = 1'b0;
                        #1;
                        chk("rst_async", ctl_zero(), 64'(0));
                        repeat (2) @(posedge clk);
                        #1;
                        chk("rst_hold", ctl_zero(), 64'(0));
                        rst_n = 1'b1;
                        @(posedge clk);
                        #1;
                        chk("rst_nodone", 64'({done, busy, pix_valid}),
                            64'(0));
                        return;
                    end
                end
                if (pix_valid && pix_ready) begin
                    k++;
                    if (k == NPIX) begin
                        exp_done = 1;
                        active   = 0;
                    end
                end
                if (cyc > 40000) begin
                    chk("timeout", 64'(0), 64'(1));
                    fin = 1;
                end
            end
            cyc++;
            @(posedge clk);
            #1;
        end
        chk("done_pulse", 64'(done), 64'(0));
        chk("beats", 64'(k), 64'(NPIX));
        chk("ndone", 64'(ndone), 64'(1));
        chk("addr_end", 64'(rd_addr), 64'(0));
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        pix_ready = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 16'(i);
        #23;
        chk("reset", ctl_zero(), 64'(0));
        chk("reset_mark", 64'({pix_sof, pix_eol, pix_eof}), 64'(3'b100));
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        scan(0, 0, 0);
        scan(1, 0, 0);
        scan(2, 0, 0);
        scan(2, 100, 1);

        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("start_abort", 64'({busy, pix_valid, done}), 64'(0));
            @(posedge clk);
            #1;
        end

        scan(0, 1000, 2);
        scan(0, 0, 0);
        scan(2, 3000, 3);
        scan(2, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
